// File: rtl/multicycle_control_if.sv
// Control-unit bus: IR/status inputs from the datapath, strobes and selects back to it.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instruction;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             mem_addr_src;
  logic             reg_write;
  logic             mem_to_reg;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic [1:0]       imm_sel;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  // Datapath side
  modport master (
    output instruction, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_src,
           reg_write, mem_to_reg, alu_src, alu_op, imm_sel, illegal, state, retired
  );

  // Control-unit side
  modport slave (
    input  instruction, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_src,
           reg_write, mem_to_reg, alu_src, alu_op, imm_sel, illegal, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// for R-type, LW, SW and BEQ and counts retired instructions.
module multicycle_control #(
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.slave bus
);

  localparam int unsigned OP_W = 7;
  localparam int unsigned ST_W = 3;

  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_NONE = 2'b00;
  localparam logic [1:0] IMM_I    = 2'b01;
  localparam logic [1:0] IMM_S    = 2'b10;
  localparam logic [1:0] IMM_B    = 2'b11;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_c;
  logic [OP_W-1:0]  opcode_c;
  logic             supported_c;
  logic             instr_unused_c;

  assign opcode_c       = bus.instruction[OP_W-1:0];
  assign supported_c    = opcode_c inside {OP_R, OP_LW, OP_SW, OP_BEQ};
  assign instr_unused_c = ^bus.instruction[31:OP_W];

  // Immediate format follows the latched opcode through EXEC and MEM
  function automatic logic [1:0] imm_for(input logic [OP_W-1:0] op);
    logic [1:0] sel;
    sel = IMM_NONE;
    case (op)
      OP_LW:   sel = IMM_I;
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
      default: sel = IMM_NONE;
    endcase
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next state, opcode latch and retire event
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = opcode_c;
        state_d = supported_c ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        case (op_q)
          OP_R:         state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (op_q == OP_LW) begin
          if (bus.mem_ready) state_d = S_WB;
        end else if (op_q == OP_SW) begin
          if (bus.mem_ready) begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_W'(retire_c);
  end

  // Datapath strobes and selects; all forced low while reset is held
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.pc_src       = 1'b0;
    bus.ir_write     = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr_src = 1'b0;
    bus.reg_write    = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.alu_src      = 1'b0;
    bus.alu_op       = ALU_ADD;
    bus.imm_sel      = IMM_NONE;
    bus.illegal      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          bus.illegal = ~supported_c;
        end
        S_EXEC: begin
          bus.imm_sel = imm_for(op_q);
          case (op_q)
            OP_R: begin
              bus.alu_src = 1'b0;
              bus.alu_op  = ALU_FUNCT;
            end
            OP_LW, OP_SW: begin
              bus.alu_src = 1'b1;
              bus.alu_op  = ALU_ADD;
            end
            OP_BEQ: begin
              bus.alu_src  = 1'b0;
              bus.alu_op   = ALU_SUB;
              bus.pc_write = bus.zero;
              bus.pc_src   = bus.zero;
            end
            default: bus.alu_op = ALU_ADD;
          endcase
        end
        S_MEM: begin
          bus.mem_addr_src = 1'b1;
          bus.imm_sel      = imm_for(op_q);
          bus.mem_read     = (op_q == OP_LW);
          bus.mem_write    = (op_q == OP_SW);
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (op_q == OP_LW);
        end
        default: bus.illegal = 1'b0;
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the RISC-V core: a state machine that sequences the shared datapath (PC, instruction register, immediate generator, ALU, register file, unified memory port) through fetch/decode/execute/memory/writeback for R-type, LW, SW and BEQ. It sits beside the datapath and drives every write enable, mux select and memory strobe. It also selects which immediate format the immediate generator must produce, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instruction  in  32  current IR contents; opcode = instruction[6:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+4, 1 = branch target (PC + immediate)
- ir_write  out  1  load IR from memory read data
- mem_read  out  1  memory read request (held until mem_ready)
- mem_write  out  1  memory write request (held until mem_ready)
- mem_addr_src  out  1  0 = PC, 1 = ALU result
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  0 = ALU result, 1 = memory data
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 subtract (compare), 10 funct-decoded
- imm_sel  out  2  00 none, 01 I (LW), 10 S (SW), 11 B (BEQ)
- illegal  out  1  one-cycle pulse: unsupported opcode decoded
- state  out  3  current state encoding (debug)
- retired  out  CNT_W  count of completed instructions

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5–7 unreachable and recover to FETCH next cycle.
- Opcodes: R 0110011, LW 0000011, SW 0100011, BEQ 1100011. The opcode is registered in DECODE (op_q); EXEC/MEM/WB use op_q only, never the live instruction input.
- FETCH: mem_read=1, mem_addr_src=0. Stays in FETCH while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE: latches op_q. A supported opcode goes to EXEC. Any other opcode asserts illegal=1 and goes to FETCH; no retire.
- EXEC:
  - R: alu_src=0, alu_op=10, go to WB.
  - LW: alu_src=1, alu_op=00, imm_sel=01, go to MEM.
  - SW: alu_src=1, alu_op=00, imm_sel=10, go to MEM.
  - BEQ: alu_src=0, alu_op=01, imm_sel=11. If zero=1: pc_write=1, pc_src=1. Retires and goes to FETCH.
- MEM: mem_addr_src=1, imm_sel held from EXEC.
  - LW: mem_read=1; stays while mem_ready=0; on mem_ready goes to WB.
  - SW: mem_write=1; stays while mem_ready=0; on mem_ready retires and goes to FETCH.
- WB: reg_write=1, mem_to_reg=(op_q==LW). Retires and goes to FETCH.
- Outputs are combinational from state, op_q, zero and mem_ready. Any strobe not listed for a state is 0. imm_sel is 00 in FETCH, DECODE and WB.
- Retire: retired increments by 1 on the clock edge leaving the final state of a supported instruction. It wraps from all-ones to 0.

## Timing
- Reset: on a clk edge with reset=1, state=FETCH, op_q=0, retired=0. While reset=1, all strobes and illegal are forced to 0 regardless of state.
- Reset mid-instruction (any state, including waiting in MEM) aborts the instruction: no retire, no write strobe on that cycle. FETCH is resumed on the first edge after reset deasserts.
- Latency with mem_ready=1 on first request (cycles from FETCH entry to next FETCH entry):
  - BEQ: 3
  - R: 4
  - SW: 4
  - LW: 5
  - Each cycle mem_ready is low adds 1 cycle in FETCH or MEM.
- mem_read and mem_write are never high simultaneously. Each stays stable until the cycle mem_ready=1.
- mem_ready outside FETCH or MEM is ignored.
- The BEQ decision uses zero sampled in the EXEC cycle only.
- illegal is high exactly one cycle, the DECODE cycle.

## Test plan
- Reset then idle: hold reset=1 three cycles with mem_ready=1 → state=0, all strobes 0, retired=0; first post-reset cycle shows mem_read=1.
- LW 32'h55578083 with mem_ready=1 → state sequence 0,1,2,3,4,0; imm_sel=01 in EXEC and MEM; reg_write=1 and mem_to_reg=1 in WB; retired=1.
- SW 32'h55FFFAA3 with mem_ready low for 2 MEM cycles → MEM held 3 cycles with mem_write=1 and mem_addr_src=1; total 6 cycles; no reg_write; retired +1.
- BEQ 32'h0FFFFF63, zero=1 then a repeat with zero=0 → first: pc_write=1, pc_src=1 in EXEC; second: pc_write=0 in EXEC; each takes 3 cycles.
- Illegal opcode 32'hFFFFFF80 → illegal=1 for one cycle in DECODE, return to FETCH, retired unchanged, no reg_write or mem_write.
- Reset asserted while in MEM during an LW with mem_ready=0 → no reg_write, retired unchanged, state=0 next edge. Separately, preload retired to 16'hFFFF and run one R-type → retired=0.
